key_debounce: RTL and testbench

Debounces one active-low front-panel push-button input and reports clean press/release events for the panel/encoder logic. It is the input-side counterpart of the LED stretcher: the LED block turns internal events into a visible indication, and this block turns a noisy mechanical contact into internal events. It sits at the FPGA pin boundary, runs in the 125 MHz domain, and takes a 25-bit runtime debounce `period` in clock cycles.

---
 rtl/key_debounce_pkg.sv | 14 +
 rtl/sync2_ff.sv | 26 ++
 rtl/key_debounce.sv | 138 +++++++++++++
 tb/tb_key_debounce.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and widths for the push-button debouncer.
package key_debounce_pkg;

    localparam int KEY_PERIOD_W = 25;
    localparam int KEY_HOLD_W   = 27;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } key_state_t;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
module sync2_ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low push-button and emits press/release (and optional long-press) strobes.
// Optional long-press detection is enabled by defining KEY_LONG_PRESS_EN.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = 125_000_000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    key_n,
    input  logic [KEY_PERIOD_W-1:0] period,
    output logic                    pressed,
    output logic                    press_pulse,
    output logic                    release_pulse,
    output logic                    long_pulse
);

    logic key_s;

    sync2_ff #(.RST_VAL(1'b1)) u_key_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (key_n),
        .q       (key_s)
    );

    key_state_t              state_q, state_d;
    logic [KEY_PERIOD_W-1:0] cnt_q, cnt_d;
    logic                    pressed_q, pressed_d;
    logic                    press_pulse_q, press_pulse_d;
    logic                    release_pulse_q, release_pulse_d;

    // cnt only increments while below period, so it can never wrap;
    // a lowered period is caught by the >= on the next cycle.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pressed_d       = pressed_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (cnt_q >= period) begin
                    state_d       = PRESSED;
                    pressed_d     = 1'b1;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + KEY_PERIOD_W'(1);
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_d = REL_WAIT;
                    cnt_d   = '0;
                end
            end
            REL_WAIT: begin
                if (!key_s) begin
                    state_d = PRESSED;
                end else if (cnt_q >= period) begin
                    state_d         = IDLE;
                    pressed_d       = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + KEY_PERIOD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [KEY_HOLD_W-1:0] LONG_SAT  = KEY_HOLD_W'(LONG_CYCLES);
    localparam logic [KEY_HOLD_W-1:0] LONG_LAST = KEY_HOLD_W'(LONG_CYCLES - 1);

    logic [KEY_HOLD_W-1:0] hold_q, hold_d;
    logic                  long_pulse_q, long_pulse_d;

    // Hold time survives release bounces (REL_WAIT -> PRESSED); saturation
    // makes the strobe one-shot, and a same-cycle release suppresses it.
    always_comb begin
        hold_d       = hold_q;
        long_pulse_d = 1'b0;
        if (press_pulse_d) begin
            hold_d = '0;
        end else if (state_q == PRESSED || state_q == REL_WAIT) begin
            if (hold_q != LONG_SAT)
                hold_d = hold_q + KEY_HOLD_W'(1);
            long_pulse_d = (hold_q == LONG_LAST) && !release_pulse_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q       <= '0;
            long_pulse_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            long_pulse_q <= long_pulse_d;
        end
    end

    assign long_pulse = long_pulse_q;
`else
    logic unused_long_cfg;
    assign unused_long_cfg = ^LONG_CYCLES;
    assign long_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random bouncing against a run-length model.
module tb_key_debounce;

    localparam int LONG = 50;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_n = 1'b1;
    logic [24:0] period = 25'd10;
    logic        pressed, press_pulse, release_pulse, long_pulse;

    key_debounce #(.LONG_CYCLES(LONG)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .key_n         (key_n),
        .period        (period),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #4 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: the debounced level flips once the synchronized key
    // has disagreed with it for period+2 consecutive FSM samples.
    bit d1 = 1'b1, d2 = 1'b1;
    bit lvl = 1'b0;
    int run = 0;
    int edge_no = 0;
    int press_edge = -100000;

    int press_cnt, rel_cnt, long_cnt;
    int press_obs_edge, long_obs_edge;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clr_counts();
        press_cnt = 0; rel_cnt = 0; long_cnt = 0;
        press_obs_edge = -1; long_obs_edge = -1;
    endtask

    task automatic tick();
        bit samp, commit, exp_press, exp_rel, exp_long;
        @(posedge clock);
        edge_no++;
        samp = d2; d2 = d1; d1 = key_n;
        if (samp == lvl) run++; else run = 0;
        commit = (run >= int'(period) + 2);
        exp_press = 1'b0; exp_rel = 1'b0;
        if (commit) begin
            lvl = ~lvl;
            run = 0;
            if (lvl) begin exp_press = 1'b1; press_edge = edge_no; end
            else exp_rel = 1'b1;
        end
`ifdef KEY_LONG_PRESS_EN
        exp_long = lvl && (edge_no == press_edge + LONG);
`else
        exp_long = 1'b0;
`endif
        #1;
        check("pressed", pressed, lvl);
        check("press_pulse", press_pulse, exp_press);
        check("release_pulse", release_pulse, exp_rel);
        check("long_pulse", long_pulse, exp_long);
        check("pulse_exclusive", press_pulse & release_pulse, 1'b0);
        if (press_pulse) begin press_cnt++; press_obs_edge = edge_no; end
        if (release_pulse) rel_cnt++;
        if (long_pulse) begin long_cnt++; long_obs_edge = edge_no; end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called 1 time unit after a posedge; asserts reset between edges.
    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        #1;
        check("rst_pressed", pressed, 1'b0);
        check("rst_press_pulse", press_pulse, 1'b0);
        check("rst_release_pulse", release_pulse, 1'b0);
        check("rst_long_pulse", long_pulse, 1'b0);
        d1 = 1'b1; d2 = 1'b1; lvl = 1'b0; run = 0; press_edge = -100000;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
    endtask

    int e0;

    initial begin
        clr_counts();
        repeat (3) @(posedge clock);
        #1;
        check("init_pressed", pressed, 1'b0);
        check("init_press_pulse", press_pulse, 1'b0);
        check("init_release_pulse", release_pulse, 1'b0);
        check("init_long_pulse", long_pulse, 1'b0);
        #2 reset_n = 1'b1;
        ticks(5);

        // Clean press and release, period 10: pulse visible after edge e0+period+3
        period = 25'd10;
        clr_counts();
        key_n = 1'b0; e0 = edge_no + 1;
        ticks(100);
        check_int("clean_press_cnt", press_cnt, 1);
        check_int("clean_press_lat", press_obs_edge - e0, 13);
        check("clean_pressed", pressed, 1'b1);
        key_n = 1'b1; e0 = edge_no + 1;
        ticks(100);
        check_int("clean_rel_cnt", rel_cnt, 1);
        check("clean_released", pressed, 1'b0);

        // Bounce: low 5 / high 3 / low 4 then settled low
        clr_counts();
        key_n = 1'b0; ticks(5);
        key_n = 1'b1; ticks(3);
        key_n = 1'b0; e0 = edge_no + 1; ticks(4);
        check_int("bounce_quiet", press_cnt, 0);
        ticks(100);
        check_int("bounce_press_cnt", press_cnt, 1);
        check_int("bounce_press_lat", press_obs_edge - e0, 13);
        key_n = 1'b1; ticks(3);
        key_n = 1'b0; ticks(2);
        key_n = 1'b1; ticks(100);
        check_int("bounce_rel_cnt", rel_cnt, 1);

        // period 0: single confirming sample
        period = 25'd0;
        clr_counts();
        key_n = 1'b0; e0 = edge_no + 1;
        ticks(10);
        check_int("p0_press_lat", press_obs_edge - e0, 3);
        key_n = 1'b1; ticks(10);
        check_int("p0_rel_cnt", rel_cnt, 1);

        // Period lowered mid-wait commits on the next cycle
        period = 25'd1000;
        clr_counts();
        key_n = 1'b0;
        ticks(200);
        check_int("pchg_no_early", press_cnt, 0);
        period = 25'd5;
        e0 = edge_no + 1;
        tick();
        check_int("pchg_commit_edge", press_obs_edge, e0);
        ticks(20);
        check("pchg_pressed", pressed, 1'b1);
        check_int("pchg_press_cnt", press_cnt, 1);
        key_n = 1'b1; ticks(20);

        // Long press, period 2
        period = 25'd2;
        clr_counts();
        key_n = 1'b0; ticks(200);
`ifdef KEY_LONG_PRESS_EN
        check_int("long_cnt", long_cnt, 1);
        check_int("long_lat", long_obs_edge - press_obs_edge, LONG);
`else
        check_int("long_cnt_off", long_cnt, 0);
`endif
        key_n = 1'b1; ticks(20);
        clr_counts();
        key_n = 1'b0; ticks(30);
        key_n = 1'b1; ticks(40);
        check_int("short_hold_no_long", long_cnt, 0);
        check_int("short_hold_rel", rel_cnt, 1);

        // Random bouncing with occasional period changes
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 3) == 0) period = 25'($urandom_range(0, 8));
            key_n = ~key_n;
            ticks($urandom_range(1, 70));
        end
        key_n = 1'b1; ticks(30);

        // Reset while pressed, key kept held through reset release
        period = 25'd3;
        key_n = 1'b0; ticks(20);
        check("pre_rst_pressed", pressed, 1'b1);
        clr_counts();
        pulse_reset();
        e0 = edge_no + 1;
        ticks(30);
        check_int("post_rst_rel_cnt", rel_cnt, 0);
        check_int("post_rst_press_cnt", press_cnt, 1);
        check_int("post_rst_press_lat", press_obs_edge - e0, 6);
        key_n = 1'b1; ticks(20);
        check_int("post_rst_rel", rel_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
